// File: rtl/seg_frame_serializer.sv
// Queues changed 7-segment vectors in a small FIFO and drains them as
// 10-bit serial frames: start, 7 data bits LSB first, even parity, stop.
module seg_frame_serializer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               seg_in,
  input  logic                     seg_valid,
  input  logic                     clr_ovf,
  output logic                     sdo,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned LAST_BIT = SEG_W - 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [SEG_W-1:0]    data_q, data_d;
  logic                sdo_d;
  logic                pop;
  logic                baud_tc;

  logic [SEG_W-1:0]    last_seg_q;
  logic [SEG_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic                push, push_acc, drop, full, empty;

  // Only vectors that differ from the previous sample are candidates.
  assign push     = seg_valid && (seg_in != last_seg_q);
  assign full     = (fifo_count == CNT_W'(DEPTH));
  assign empty    = (fifo_count == '0);
  assign push_acc = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign baud_tc  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      sdo     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      sdo     <= sdo_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Next-state logic; sdo_d is the line level for the cycle after this edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_tc ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    sdo_d   = sdo;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        sdo_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = mem[rd_ptr_q];
          state_d = START;
          sdo_d   = 1'b0;
        end
      end
      START: begin
        if (baud_tc) begin
          state_d = DATA;
          bit_d   = '0;
          sdo_d   = data_q[0];
        end
      end
      DATA: begin
        if (baud_tc) begin
          if (bit_q == 3'(LAST_BIT)) begin
            state_d = PARITY;
            sdo_d   = ^data_q;
          end else begin
            bit_d = bit_q + 3'd1;
            sdo_d = data_q[bit_d];
          end
        end
      end
      PARITY: begin
        if (baud_tc) begin
          state_d = STOP;
          sdo_d   = 1'b1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            data_d  = mem[rd_ptr_q];
            state_d = START;
            sdo_d   = 1'b0;
          end else begin
            state_d = IDLE;
            sdo_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sdo_d   = 1'b1;
      end
    endcase
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= seg_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      last_seg_q <= '0;
      overflow   <= 1'b0;
    end else begin
      if (seg_valid) last_seg_q <= seg_in;
      if (push_acc)  wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
      case ({push_acc, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
